// File: rtl/mc_alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op encoding and handshake FSM states.
// Op 111 (divide) only exists when MC_ALU_DIV_EN is defined.
package mc_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_DIV = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ops that need the iterative datapath rather than a single-cycle result.
    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mc_alu_if.sv
// Operand/result handshake bundle between the register-read stage, mc_alu and writeback.
interface mc_alu_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       ALUControl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, A, B, ALUControl, out_ready,
        input  in_ready, out_valid, result, zero, cout, overflow, illegal
    );

    modport slave (
        input  in_valid, A, B, ALUControl, out_ready,
        output in_ready, out_valid, result, zero, cout, overflow, illegal
    );

endinterface

// File: rtl/mc_alu_iter.sv
// Iterative datapath: shift-add multiply and, with MC_ALU_DIV_EN, restoring divide.
// One step per cycle for WIDTH cycles; o_done marks the final step and o_result is its outcome.
module mc_alu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
`ifdef MC_ALU_DIV_EN
    input  logic             i_div,
`endif
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    logic             r_active;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_mcand_nx;
    logic [WIDTH-1:0] w_mplier_nx;
    logic [WIDTH-1:0] w_acc_nx;
`ifdef MC_ALU_DIV_EN
    // For divide: r_mcand holds the divisor, r_mplier the dividend/quotient, r_acc the remainder.
    logic             r_div;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_rem_sub;
`endif

    // Next-step values of the working registers.
    always_comb begin
        w_mcand_nx  = r_mcand << 1;
        w_mplier_nx = r_mplier >> 1;
        if (r_mplier[0]) begin
            w_acc_nx = r_acc + r_mcand;
        end else begin
            w_acc_nx = r_acc;
        end
`ifdef MC_ALU_DIV_EN
        w_rem_sh  = {r_acc, r_mplier[WIDTH-1]};
        w_rem_sub = w_rem_sh - {1'b0, r_mcand};
        if (r_div) begin
            w_mcand_nx = r_mcand;
            if (!w_rem_sub[WIDTH]) begin
                w_acc_nx    = w_rem_sub[WIDTH-1:0];
                w_mplier_nx = {r_mplier[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nx    = w_rem_sh[WIDTH-1:0];
                w_mplier_nx = {r_mplier[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_mcand_nx = r_mcand << 1;
        end
`endif
    end

    // Working registers and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= {CNT_W{1'b0}};
            r_mcand  <= {WIDTH{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_acc    <= {WIDTH{1'b0}};
`ifdef MC_ALU_DIV_EN
            r_div    <= 1'b0;
`endif
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= CNT_W'(WIDTH);
            r_acc    <= {WIDTH{1'b0}};
`ifdef MC_ALU_DIV_EN
            r_div    <= i_div;
            r_mcand  <= i_div ? i_b : i_a;
            r_mplier <= i_div ? i_a : i_b;
`else
            r_mcand  <= i_a;
            r_mplier <= i_b;
`endif
        end else if (r_active) begin
            r_mcand  <= w_mcand_nx;
            r_mplier <= w_mplier_nx;
            r_acc    <= w_acc_nx;
            r_cnt    <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_done = r_active && (r_cnt == CNT_W'(1));
`ifdef MC_ALU_DIV_EN
    assign o_result = r_div ? w_mplier_nx : w_acc_nx;
`else
    assign o_result = w_acc_nx;
`endif

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle 32-bit-class ALU with valid/ready handshake; single-cycle ops plus iterative multiply.
// Define MC_ALU_DIV_EN to add unsigned restoring divide on op 111 (otherwise flagged illegal).
module mc_alu
    import mc_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic     clk,
    input logic     rst_n,
    mc_alu_if.slave bus
);

    state_e           r_state;
    state_e           w_state_nx;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_cout;
    logic             r_overflow;
    logic             r_illegal;

    logic             w_accept;
    logic             w_use_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum_ext;
    logic             w_add_ovf;
    logic [WIDTH-1:0] w_sc_result;
    logic             w_sc_cout;
    logic             w_sc_ovf;
    logic             w_sc_illegal;
    logic             w_iter_op;
    logic             w_iter_done;
    logic [WIDTH-1:0] w_iter_result;

    assign w_accept  = bus.in_valid && (r_state == ST_IDLE);
    assign w_use_sub = (bus.ALUControl == OP_SUB) || (bus.ALUControl == OP_SLT);
    assign w_b_eff   = w_use_sub ? ~bus.B : bus.B;
    assign w_sum_ext = {1'b0, bus.A} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_use_sub};
    assign w_add_ovf = (bus.A[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum_ext[WIDTH-1] != bus.A[WIDTH-1]);

    // Single-cycle op decode; iterative ops only raise w_iter_op.
    always_comb begin
        w_sc_result  = {WIDTH{1'b0}};
        w_sc_cout    = 1'b0;
        w_sc_ovf     = 1'b0;
        w_sc_illegal = 1'b0;
        w_iter_op    = 1'b0;
        case (bus.ALUControl)
            OP_ADD, OP_SUB: begin
                w_sc_result = w_sum_ext[WIDTH-1:0];
                w_sc_cout   = w_sum_ext[WIDTH];
                w_sc_ovf    = w_add_ovf;
            end
            OP_AND:  w_sc_result = bus.A & bus.B;
            OP_XOR:  w_sc_result = bus.A ^ bus.B;
            OP_OR:   w_sc_result = bus.A | bus.B;
            // Sign of the difference corrected by overflow gives the true signed compare.
            OP_SLT:  w_sc_result = {{(WIDTH-1){1'b0}}, w_sum_ext[WIDTH-1] ^ w_add_ovf};
            OP_MUL:  w_iter_op = is_iter_op(bus.ALUControl);
            OP_DIV: begin
`ifdef MC_ALU_DIV_EN
                if (bus.B == {WIDTH{1'b0}}) begin
                    w_sc_result  = {WIDTH{1'b1}};
                    w_sc_illegal = 1'b1;
                end else begin
                    w_iter_op = is_iter_op(bus.ALUControl);
                end
`else
                w_sc_illegal = 1'b1;
`endif
            end
            default: w_sc_illegal = 1'b1;
        endcase
    end

    mc_alu_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_accept && w_iter_op),
`ifdef MC_ALU_DIV_EN
        .i_div    (bus.ALUControl == OP_DIV),
`endif
        .i_a      (bus.A),
        .i_b      (bus.B),
        .o_done   (w_iter_done),
        .o_result (w_iter_result)
    );

    // Handshake FSM next state.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nx = w_iter_op ? ST_BUSY : ST_DONE;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (w_iter_done) begin
                    w_state_nx = ST_DONE;
                end else begin
                    w_state_nx = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_DONE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Result and flag registers; held unchanged through BUSY and DONE until a new load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result   <= {WIDTH{1'b0}};
            r_zero     <= 1'b0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_accept && !w_iter_op) begin
            r_result   <= w_sc_result;
            r_zero     <= (w_sc_result == {WIDTH{1'b0}});
            r_cout     <= w_sc_cout;
            r_overflow <= w_sc_ovf;
            r_illegal  <= w_sc_illegal;
        end else if ((r_state == ST_BUSY) && w_iter_done) begin
            r_result   <= w_iter_result;
            r_zero     <= (w_iter_result == {WIDTH{1'b0}});
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.cout      = r_cout;
    assign bus.overflow  = r_overflow;
    assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_mc_alu.sv
// Scoreboard bench for mc_alu: stimulus pushes model expectations, a negedge monitor checks each result.
module tb_mc_alu;
    import mc_alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_alu_if #(.WIDTH(W)) bus();
    mc_alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;     // {zero, cout, overflow, illegal}
        int          lat;     // cycle after the accept edge in which out_valid first shows
        int          acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rdy_mode = 0;       // 0: always ready, 1: random, 2: stalled
    bit   front_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0)      bus.out_ready = 1'b1;
        else if (rdy_mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
        else                    bus.out_ready = 1'b0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference model from the op definitions, using wide/signed arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, sr;
        logic [63:0] wide;
        logic cout, ovf, ill;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        cout = 1'b0; ovf = 1'b0; ill = 1'b0;
        e.lat = 1;
        e.res = 32'h0;
        case (op)
            3'd0: begin
                wide = {32'h0, a} + {32'h0, b};
                e.res = wide[31:0]; cout = wide[32];
                sr = sa + sb; ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd1: begin
                e.res = a - b; cout = (a >= b);
                sr = sa - sb; ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd2: e.res = a & b;
            3'd3: e.res = a ^ b;
            3'd4: e.res = a | b;
            3'd5: e.res = (sa < sb) ? 32'd1 : 32'd0;
            3'd6: begin
                wide = {32'h0, a} * {32'h0, b};
                e.res = wide[31:0]; e.lat = 33;
            end
            default: begin
`ifdef MC_ALU_DIV_EN
                if (b == 32'h0) begin
                    e.res = 32'hFFFF_FFFF; ill = 1'b1;
                end else begin
                    e.res = a / b; e.lat = 33;
                end
`else
                e.res = 32'h0; ill = 1'b1;
`endif
            end
        endcase
        e.flg = {(e.res == 32'h0), cout, ovf, ill};
        e.acc_cyc = 0;
        return e;
    endfunction

    // Monitor: checks every cycle a result is presented, pops on completed transfer.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_output: got result %h expected none", bus.result);
            end else begin
                chk("result", 64'(bus.result), 64'(sb_q[0].res));
                chk("flags", 64'({bus.zero, bus.cout, bus.overflow, bus.illegal}), 64'(sb_q[0].flg));
                chk("in_ready_in_done", 64'(bus.in_ready), 64'd0);
                if (!front_seen) begin
                    chk("latency", 64'(cyc - sb_q[0].acc_cyc + 1), 64'(sb_q[0].lat));
                    front_seen = 1'b1;
                end
                if (bus.out_ready) begin
                    void'(sb_q.pop_front());
                    front_seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_out, input bit hold);
        exp_t e;
        int   n;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
        end
        if (n >= 300) begin
            chk("issue_wait_ready", 64'd0, 64'd1);
            return;
        end
        bus.in_valid = 1'b1; bus.A = a; bus.B = b; bus.ALUControl = op;
        @(posedge clk);
        #1;
        e = model(op, a, b);
        e.acc_cyc = cyc;
        if (expect_out) sb_q.push_back(e);
        if (hold) begin
            n = 0;
            while (n < 60) begin
                @(negedge clk);
                if (bus.out_valid) break;
                chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
                n++;
            end
            if (n >= 60) chk("busy_timeout", 64'd0, 64'd1);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        bus.in_valid = 1'b0; bus.A = 32'h0; bus.B = 32'h0; bus.ALUControl = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_result", 64'(bus.result), 64'd0);
        chk("reset_flags", 64'({bus.zero, bus.cout, bus.overflow, bus.illegal}), 64'd0);
        rst_n = 1'b1;

        // Abort a multiply with reset; nothing may come out.
        issue(OP_MUL, 32'd7, 32'd9, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        chk("abort_result", 64'(bus.result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_abort_out_valid", 64'(bus.out_valid), 64'd0);
        end
        issue(OP_ADD, 32'd1, 32'd1, 1'b1, 1'b0);

        // Directed boundaries.
        issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0);
        issue(OP_SUB, 32'd5, 32'd5, 1'b1, 1'b0);
        issue(OP_SLT, 32'h8000_0000, 32'd1, 1'b1, 1'b0);
        issue(OP_SLT, 32'd1, 32'h8000_0000, 1'b1, 1'b0);
        issue(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 1'b0);
        issue(OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1, 1'b0);
        issue(OP_OR,  32'h0000_1200, 32'h0034_0000, 1'b1, 1'b0);
        issue(OP_DIV, 32'd100, 32'd7, 1'b1, 1'b0);
        issue(OP_DIV, 32'd5, 32'd0, 1'b1, 1'b0);
        drain();

        // Multiply with in_valid held through BUSY, then 10 cycles of backpressure.
        rdy_mode = 2;
        issue(OP_MUL, 32'h0000_FFFF, 32'h0001_0001, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        rdy_mode = 0;
        drain();

        // Random ops with random consumer stalls.
        rdy_mode = 1;
        repeat (60) issue(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), 1'b1, 1'b0);
        rdy_mode = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: got still running expected finished");
        $fatal(1, "timeout");
    end

endmodule
